seg_scan_decoder: RTL and testbench

Recovers the displayed value from a multiplexed 6-digit common-anode seven-segment bus: the active-low digit selects plus the active-low segment and dot lines produced by our `seg_driver`. It samples each digit slot once its select has settled, decodes segment patterns back to BCD digits, and reassembles the binary magnitude, sign and dot mask. It serves as an on-board loopback monitor and as the checker model for display benches.

---
 rtl/seg_scan_decoder.sv | 169 ++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers magnitude, sign and dot mask from a
// multiplexed 6-digit common-anode seven-segment bus.
module seg_scan_decoder #(
   parameter int unsigned SETTLE = 16
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic [5:0]  dig_sel,
   input  logic [7:0]  dig_seg,
   output logic [23:0] data_out,
   output logic        sign,
   output logic [5:0]  point,
   output logic        frame_valid,
   output logic        frame_err
);
   localparam int CW = $clog2(SETTLE + 1);
   localparam logic [CW-1:0] SAT  = CW'(SETTLE);
   localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

   typedef enum logic [1:0] {COLLECT, ASSEMBLE, PUBLISH} state_t;

   // {legal, slot index}
   function automatic logic [3:0] slot_of(input logic [5:0] s);
      logic [3:0] r;
      case (s)
         6'b011111: r = 4'b1_000;
         6'b101111: r = 4'b1_001;
         6'b110111: r = 4'b1_010;
         6'b111011: r = 4'b1_011;
         6'b111101: r = 4'b1_100;
         6'b111110: r = 4'b1_101;
         default:   r = 4'b0_000;
      endcase
      return r;
   endfunction

   // {bad, bcd digit}
   function automatic logic [4:0] seg_dec(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'b1000000: r = 5'd0;
         7'b1111001: r = 5'd1;
         7'b0100100: r = 5'd2;
         7'b0110000: r = 5'd3;
         7'b0011001: r = 5'd4;
         7'b0010010: r = 5'd5;
         7'b0000010: r = 5'd6;
         7'b1111000: r = 5'd7;
         7'b0000000: r = 5'd8;
         7'b0010000: r = 5'd9;
         default:    r = 5'b1_0000;
      endcase
      return r;
   endfunction

   function automatic logic frame_bad(input logic [5:0][6:0] s);
      logic b;
      logic [4:0] d;
      b = (s[5] != 7'b0111111) && (s[5] != 7'b1111111);
      for (int k = 0; k < 5; k++) begin
         d = seg_dec(s[k]);
         b = b | d[4];
      end
      return b;
   endfunction

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [5:0]      sel_q;
   logic [5:0][6:0] seg_buf;
   logic [5:0]      dot_buf;
   logic [5:0]      mask;
   logic [5:0][6:0] shd_seg;
   logic [5:0]      shd_dot;
   logic [23:0]     acc;
   logic [2:0]      idx;

   logic [3:0] sel_now;
   logic [3:0] sel_reg;
   logic       cap;
   logic [4:0] cur;
   logic       bad;
   logic       minus;
   logic [5:0] mask_nxt;

   assign sel_now = slot_of(dig_sel);
   assign sel_reg = slot_of(sel_q);
   assign cap     = (cnt == LAST);
   assign cur     = seg_dec(shd_seg[idx]);
   assign bad     = frame_bad(shd_seg);
   assign minus   = (shd_seg[5] == 7'b0111111);

   always_comb begin
      mask_nxt = mask;
      if (state == COLLECT && (&mask))
         mask_nxt = '0;
      if (cap)
         mask_nxt[sel_reg[2:0]] = 1'b1;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         sel_q <= 6'h3f;
         cnt   <= '0;
      end else begin
         sel_q <= dig_sel;
         if (dig_sel != sel_q || !sel_now[3])
            cnt <= '0;
         else if (cnt != SAT)
            cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state       <= COLLECT;
         mask        <= '0;
         seg_buf     <= '1;
         dot_buf     <= '1;
         shd_seg     <= '1;
         shd_dot     <= '1;
         acc         <= '0;
         idx         <= '0;
         data_out    <= '0;
         sign        <= 1'b0;
         point       <= 6'h3f;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         mask        <= mask_nxt;
         if (cap) begin
            seg_buf[sel_reg[2:0]] <= dig_seg[6:0];
            dot_buf[sel_reg[2:0]] <= dig_seg[7];
         end
         unique case (state)
            COLLECT: begin
               if (&mask) begin
                  shd_seg <= seg_buf;
                  shd_dot <= dot_buf;
                  acc     <= '0;
                  idx     <= 3'd4;
                  state   <= ASSEMBLE;
               end
            end
            ASSEMBLE: begin
               acc <= acc * 24'd10 + {20'd0, cur[3:0]};
               if (idx == 3'd0)
                  state <= PUBLISH;
               else
                  idx <= idx - 3'd1;
            end
            PUBLISH: begin
               if (!bad) begin
                  data_out    <= acc;
                  sign        <= minus;
                  point       <= shd_dot;
                  frame_valid <= 1'b1;
               end else begin
                  frame_err <= 1'b1;
               end
               state <= COLLECT;
            end
            default: state <= COLLECT;
         endcase
      end
   end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: random and directed scans checked against
// a frame-level model of the display bus.
module tb_seg_scan_decoder;
   localparam int SETTLE = 8;

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b1;
   logic [5:0]  dig_sel = 6'h3f;
   logic [7:0]  dig_seg = 8'hff;
   logic [23:0] data_out;
   logic        sign;
   logic [5:0]  point;
   logic        frame_valid;
   logic        frame_err;

   seg_scan_decoder #(.SETTLE(SETTLE)) dut (
      .Clk(Clk),
      .Rst_n(Rst_n),
      .dig_sel(dig_sel),
      .dig_seg(dig_seg),
      .data_out(data_out),
      .sign(sign),
      .point(point),
      .frame_valid(frame_valid),
      .frame_err(frame_err)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   logic [6:0] seg_tab [10];
   initial begin
      seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
      seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
      seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
      seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
      seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
   end

   typedef struct {
      int         due;
      bit         ok;
      int         val;
      bit         sgn;
      logic [5:0] pt;
   } ev_t;

   ev_t        evq[$];
   ev_t        e_cur;
   bit         e_hit;
   logic [6:0] m_seg [6];
   logic       m_dot [6];
   bit         m_mask [6];
   int         p_val = 0;
   bit         p_sgn = 1'b0;
   logic [5:0] p_pt = 6'h3f;
   int         cyc = 0;
   int         n_fv = 0;
   int         n_fe = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   function automatic int seg2dig(input logic [6:0] s);
      for (int i = 0; i < 10; i++)
         if (seg_tab[i] == s) return i;
      return -1;
   endfunction

   function automatic int slot_idx(input logic [5:0] s);
      for (int k = 0; k < 6; k++)
         if (s == ~(6'b100000 >> k)) return k;
      return -1;
   endfunction

   task automatic model_reset();
      evq.delete();
      for (int k = 0; k < 6; k++) m_mask[k] = 0;
      p_val = 0;
      p_sgn = 0;
      p_pt  = 6'h3f;
   endtask

   task automatic model_capture(input int k, input logic [7:0] seg,
                                input int c);
      ev_t e;
      int  p;
      int  d;
      bit  full;
      m_seg[k]  = seg[6:0];
      m_dot[k]  = seg[7];
      m_mask[k] = 1;
      full = 1;
      for (int j = 0; j < 6; j++) if (!m_mask[j]) full = 0;
      if (!full) return;
      e.due = c + 7;
      e.ok  = 1;
      e.val = 0;
      p = 1;
      for (int j = 0; j < 5; j++) begin
         d = seg2dig(m_seg[j]);
         if (d < 0) e.ok = 0;
         else e.val += d * p;
         p *= 10;
      end
      if (m_seg[5] == 7'b0111111) e.sgn = 1;
      else if (m_seg[5] == 7'b1111111) e.sgn = 0;
      else begin
         e.sgn = 0;
         e.ok  = 0;
      end
      for (int j = 0; j < 6; j++) e.pt[j] = m_dot[j];
      evq.push_back(e);
      for (int j = 0; j < 6; j++) m_mask[j] = 0;
   endtask

   // Called at a falling edge; holds the pattern for n rising edges.
   task automatic dwell(input logic [5:0] sel, input logic [7:0] seg,
                        input int n);
      int k;
      dig_sel = sel;
      dig_seg = seg;
      k = slot_idx(sel);
      if (k >= 0 && n >= SETTLE)
         model_capture(k, seg, cyc + 1 + SETTLE);
      repeat (n) @(negedge Clk);
   endtask

   function automatic logic [7:0] slot_seg(input int k, input int val,
                                           input bit neg,
                                           input logic [5:0] pt);
      int p;
      p = 1;
      for (int j = 0; j < k; j++) p *= 10;
      if (k == 5) return {pt[5], neg ? 7'b0111111 : 7'b1111111};
      return {pt[k], seg_tab[(val / p) % 10]};
   endfunction

   task automatic scan(input int val, input bit neg, input logic [5:0] pt,
                       input int n, input int bad_k,
                       input logic [6:0] bad_pat);
      logic [7:0] s;
      for (int k = 0; k < 6; k++) begin
         s = slot_seg(k, val, neg, pt);
         if (k == bad_k) s[6:0] = bad_pat;
         dwell(~(6'b100000 >> k), s, n);
      end
   endtask

   always @(negedge Clk) begin
      e_hit = 0;
      if (evq.size() > 0 && evq[0].due == cyc) begin
         e_cur = evq.pop_front();
         e_hit = 1;
      end
      if (frame_valid) n_fv++;
      if (frame_err) n_fe++;
      chk("frame_valid", frame_valid, e_hit && e_cur.ok);
      chk("frame_err", frame_err, e_hit && !e_cur.ok);
      if (e_hit && e_cur.ok) begin
         p_val = e_cur.val;
         p_sgn = e_cur.sgn;
         p_pt  = e_cur.pt;
      end
      chk("data_out", data_out, p_val);
      chk("sign", sign, p_sgn);
      chk("point", point, p_pt);
   end

   initial begin
      int fv0;
      int fe0;
      int val;
      int n;
      bit neg;
      logic [5:0] pt;
      logic [7:0] s;
      model_reset();
      #1 Rst_n = 1'b0;
      repeat (3) @(negedge Clk);
      chk("rst_data", data_out, 0);
      chk("rst_point", point, 6'h3f);
      Rst_n = 1'b1;
      dwell(6'h3f, 8'hff, 3);

      scan(12345, 1, 6'b111011, 20, -1, 7'h0);
      scan(12345, 1, 6'b111011, 20, -1, 7'h0);
      dwell(6'h3f, 8'hff, 12);
      chk("loop_frames", n_fv, 2);
      chk("loop_val", data_out, 12345);

      scan(99999, 0, 6'h3f, 12, -1, 7'h0);
      dwell(6'h3f, 8'hff, 12);
      chk("nines", data_out, 99999);

      fv0 = n_fv;
      fe0 = n_fe;
      scan(54321, 1, 6'h15, 11, 2, 7'b0000001);
      dwell(6'h3f, 8'hff, 12);
      chk("err_pulse", n_fe - fe0, 1);
      chk("err_novalid", n_fv - fv0, 0);
      chk("err_hold", data_out, 99999);

      fv0 = n_fv;
      fe0 = n_fe;
      scan(11111, 0, 6'h3f, SETTLE - 1, -1, 7'h0);
      dwell(6'h3f, 8'hff, 20);
      chk("short_none", (n_fv - fv0) + (n_fe - fe0), 0);

      for (int k = 0; k < 6; k++) begin
         dwell(~(6'b100000 >> k), slot_seg(k, 24680, 1, 6'h2a), 10);
         dwell((k % 2) ? 6'b001111 : 6'b111111, 8'h00, 9);
      end
      dwell(6'h3f, 8'hff, 12);
      chk("illegal_sel", data_out, 24680);

      for (int k = 0; k < 5; k++)
         dwell(~(6'b100000 >> k), slot_seg(k, 77777, 0, 6'h3f), 10);
      dwell(6'b111110, slot_seg(5, 77777, 0, 6'h3f), SETTLE + 4);
      fv0 = n_fv;
      #1;
      Rst_n = 1'b0;
      dig_sel = 6'h3f;
      model_reset();
      @(negedge Clk);
      chk("mid_rst_data", data_out, 0);
      chk("mid_rst_point", point, 6'h3f);
      @(negedge Clk);
      Rst_n = 1'b1;
      dwell(6'h3f, 8'hff, 12);
      chk("mid_rst_nopulse", n_fv - fv0, 0);
      scan(31415, 1, 6'h3e, 10, -1, 7'h0);
      dwell(6'h3f, 8'hff, 12);
      chk("after_rst", data_out, 31415);

      for (int f = 0; f < 20; f++) begin
         val = $urandom_range(0, 99999);
         neg = 1'($urandom_range(0, 1));
         pt  = 6'($urandom_range(0, 63));
         for (int k = 0; k < 6; k++) begin
            n = ($urandom_range(0, 9) == 0) ? SETTLE - 1
                : SETTLE + 1 + $urandom_range(0, 5);
            s = slot_seg(k, val, neg, pt);
            if ($urandom_range(0, 15) == 0)
               s[6:0] = 7'($urandom_range(0, 127));
            dwell(~(6'b100000 >> k), s, n);
            if ($urandom_range(0, 7) == 0)
               dwell(($urandom_range(0, 1) != 0) ? 6'h00 : 6'h3f,
                     8'($urandom_range(0, 255)),
                     $urandom_range(1, 12));
         end
      end
      dwell(6'h3f, 8'hff, 40);
      chk("pending", evq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
